// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT row/column datapath: FSM states, row length,
// accumulator sizing and a width-parametrised signed saturation.
package dct_pkg;

   typedef enum logic [1:0] {LOAD, FETCH, DRAIN, OUT} state_t;

   localparam int ROW_LEN = 8;

   // Eight products summed: three guard bits above the full product width.
   function automatic int acc_width(input int sample_w, input int word_w);
      return sample_w + word_w + 3;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/dct_sat_round.sv
// Combinational accumulator-to-output scaling: optional round, arithmetic shift, saturate.
// Build option: define DCT_ROUND_EN for round-half-up; otherwise the shift truncates toward -inf.
module dct_sat_round
   import dct_pkg::*;
#(
   parameter int ACC_W     = 35,
   parameter int FRAC_BITS = 14,
   parameter int OUT_WIDTH = 12
) (
   input  logic signed [ACC_W-1:0]     i_acc,
   output logic signed [OUT_WIDTH-1:0] o_data
);

   // One extra bit so the rounding bias can never wrap the accumulator.
   logic signed [ACC_W:0] w_biased;
   logic signed [ACC_W:0] w_shifted;

`ifdef DCT_ROUND_EN
   localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(2 ** (FRAC_BITS - 1));
   assign w_biased = {i_acc[ACC_W-1], i_acc} + HALF;
`else
   assign w_biased = {i_acc[ACC_W-1], i_acc};
`endif

   assign w_shifted = w_biased >>> FRAC_BITS;
   assign o_data    = OUT_WIDTH'(saturate(64'(w_shifted), OUT_WIDTH));

endmodule

// File: rtl/dct_row_mac.sv
// 1-D 8-point DCT row engine: loads a row, MACs it against ROM coefficients, streams y[0..7].
// Build option: DCT_ROUND_EN selects rounding in dct_sat_round; latency is unchanged.
module dct_row_mac
   import dct_pkg::*;
#(
   parameter int SAMPLE_WIDTH  = 8,
   parameter int WORD_WIDTH    = 24,
   parameter int ADDRESS_WIDTH = 6,
   parameter int FRAC_BITS     = 14,
   parameter int OUT_WIDTH     = 12
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic signed [SAMPLE_WIDTH-1:0]  in_sample,
   output logic [ADDRESS_WIDTH-1:0]        rom_address,
   output logic                            rom_read_en,
   input  logic [WORD_WIDTH-1:0]           rom_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic signed [OUT_WIDTH-1:0]     out_data,
   output logic [2:0]                      out_index,
   output logic                            busy
);

   localparam int ACC_W  = acc_width(SAMPLE_WIDTH, WORD_WIDTH);
   localparam int PROD_W = SAMPLE_WIDTH + WORD_WIDTH;

   state_t                          r_state;
   logic [2:0]                      r_cnt;
   logic [2:0]                      r_k;
   logic [2:0]                      r_n_p1;
   logic                            r_vld_p1;
   logic signed [ACC_W-1:0]         r_acc;
   logic signed [SAMPLE_WIDTH-1:0]  r_x [ROW_LEN];
   logic                            r_in_ready;
   logic                            r_out_valid;
   logic                            r_rom_read_en;
   logic                            r_busy;
   logic [ADDRESS_WIDTH-1:0]        r_rom_address;
   logic signed [OUT_WIDTH-1:0]     r_out_data;

   logic                            w_accept;
   logic signed [PROD_W-1:0]        w_prod;
   logic signed [ACC_W-1:0]         w_acc_next;
   logic signed [OUT_WIDTH-1:0]     w_result;

   function automatic logic [ADDRESS_WIDTH-1:0] rom_addr(input logic [2:0] k,
                                                         input logic [2:0] n);
      return ADDRESS_WIDTH'({k, n});
   endfunction

   assign w_accept   = in_valid & r_in_ready;
   assign w_prod     = r_x[r_n_p1] * $signed(rom_data);
   assign w_acc_next = r_acc + ACC_W'(w_prod);

   dct_sat_round #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat_round (
      .i_acc  (w_acc_next),
      .o_data (w_result)
   );

   // Stage p0: ROM address/strobe issued; stage p1: rom_data arrives and is accumulated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= LOAD;
         r_cnt         <= 3'd0;
         r_k           <= 3'd0;
         r_n_p1        <= 3'd0;
         r_vld_p1      <= 1'b0;
         r_acc         <= '0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_rom_read_en <= 1'b0;
         r_rom_address <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_vld_p1 <= r_rom_read_en;
         r_n_p1   <= r_cnt;
         if (r_vld_p1) r_acc <= w_acc_next;
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  if (r_cnt == 3'd7) begin
                     r_state       <= FETCH;
                     r_cnt         <= 3'd0;
                     r_k           <= 3'd0;
                     r_acc         <= '0;
                     r_in_ready    <= 1'b0;
                     r_busy        <= 1'b1;
                     r_rom_read_en <= 1'b1;
                     r_rom_address <= rom_addr(3'd0, 3'd0);
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            FETCH: begin
               if (r_cnt == 3'd7) begin
                  r_state       <= DRAIN;
                  r_rom_read_en <= 1'b0;
               end else begin
                  r_cnt         <= r_cnt + 3'd1;
                  r_rom_address <= rom_addr(r_k, r_cnt + 3'd1);
               end
            end
            // The final product lands this cycle, so the result is taken from w_acc_next.
            DRAIN: begin
               r_state     <= OUT;
               r_out_valid <= 1'b1;
               r_out_data  <= w_result;
            end
            OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_cnt       <= 3'd0;
                  if (r_k == 3'd7) begin
                     r_state    <= LOAD;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_k        <= 3'd0;
                  end else begin
                     r_state       <= FETCH;
                     r_k           <= r_k + 3'd1;
                     r_acc         <= '0;
                     r_rom_read_en <= 1'b1;
                     r_rom_address <= rom_addr(r_k + 3'd1, 3'd0);
                  end
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   // Row register is pure data: every row overwrites all eight entries before use.
   always_ff @(posedge clk) begin
      if (w_accept) r_x[r_cnt] <= in_sample;
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_index   = r_k;
   assign rom_read_en = r_rom_read_en;
   assign rom_address = r_rom_address;
   assign busy        = r_busy;

endmodule

// File: tb/tb_dct_row_mac.sv
// Scoreboard bench for dct_row_mac: a behavioural DCT row model feeds an expected-result queue
// that an independent monitor drains on every output handshake.
`timescale 1ns/1ps
module tb_dct_row_mac;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [7:0]  in_sample = '0;
   logic [5:0]         rom_address;
   logic               rom_read_en;
   logic [23:0]        rom_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [11:0] out_data;
   logic [2:0]         out_index;
   logic               busy;

   dct_row_mac dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
      .rom_address(rom_address), .rom_read_en(rom_read_en), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int k; longint v; } exp_t;
   exp_t exp_q[$];
   int   rom[64];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   rd_cnt = 0;
   int   rd_bad = 0;
   int   t_first = 0;
   int   t_done = 0;
   bit   rand_bp = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rom_read_en) rom_data <= rom[rom_address][23:0];
   end

   function automatic void check(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic void fail(string name);
      n_chk++;
      $display("FAIL %s: got timeout, expected event within cycle budget", name);
   endfunction

   // Reference: y[k] = floor((sum_n x[n]*C[k][n] (+ half)) / 2^14), clamped to 12-bit signed.
   function automatic void push_expected(input int xs[8]);
      for (int k = 0; k < 8; k++) begin
         longint s;
         s = 0;
         for (int n = 0; n < 8; n++) s += longint'(xs[n]) * longint'(rom[k*8 + n]);
`ifdef DCT_ROUND_EN
         s += 8192;
`endif
         s = s >>> 14;
         if (s > 2047) s = 2047;
         else if (s < -2048) s = -2048;
         exp_q.push_back('{k: k, v: s});
      end
   endfunction

   function automatic void set_rom_const(input int v);
      for (int i = 0; i < 64; i++) rom[i] = v;
   endfunction

   function automatic void set_rom_identity();
      for (int i = 0; i < 64; i++) rom[i] = ((i / 8) == (i % 8)) ? 16384 : 0;
   endfunction

   function automatic void check_reset_outputs(string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_index"}, out_index, 0);
      check({tag, "_rom_read_en"}, rom_read_en, 0);
      check({tag, "_rom_address"}, rom_address, 0);
      check({tag, "_busy"}, busy, 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_samples(input int xs[8], input int count, input int gap);
      int t;
      for (int n = 0; n < count; n++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, gap)) tick();
         in_valid  = 1'b1;
         in_sample = 8'(xs[n]);
         t = 0;
         while (!in_ready && t < 400) begin
            tick();
            t++;
         end
         if (!in_ready) begin
            fail("in_ready_wait");
            in_valid = 1'b0;
            return;
         end
         if (n == 0) t_first = cyc;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_row(input int xs[8], input int gap);
      push_expected(xs);
      drive_samples(xs, 8, gap);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !in_ready) && t < 3000) begin
         tick();
         t++;
      end
      if (exp_q.size() != 0 || !in_ready) fail("row_complete");
      t_done = cyc;
   endtask

   task automatic wait_index(input int k, input bit need_rd);
      int t;
      t = 0;
      while (!(out_index == 3'(k) && !out_valid && (!need_rd || rom_read_en)) && t < 400) begin
         tick();
         t++;
      end
      if (t >= 400) fail("wait_index");
   endtask

   task automatic pulse_reset(string tag);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_outputs(tag);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitor: every accepted output must match the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rom_read_en) rd_cnt++;
            if (rom_read_en && (out_valid || in_ready)) rd_bad++;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_output: got k=%0d data=%0d, expected none",
                           out_index, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("out_index", out_index, e.k);
                  check("out_data", out_data, e.v);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int xs[8];
      int d0;
      int i0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      set_rom_identity();
      rd_cnt = 0;
      xs = '{1, 2, 3, 4, 5, 6, 7, 8};
      send_row(xs, 0);
      wait_idle();
      check("rom_read_cycles", rd_cnt, 64);
      check("row_cycles", t_done - t_first, 88);

      set_rom_const(16384);
      xs = '{127, 127, 127, 127, 127, 127, 127, 127};
      send_row(xs, 1);
      wait_idle();
      xs = '{-128, -128, -128, -128, -128, -128, -128, -128};
      send_row(xs, 1);
      wait_idle();

      set_rom_const(65536);
      xs = '{127, 127, 127, 127, 127, 127, 127, 127};
      send_row(xs, 0);
      wait_idle();
      xs = '{-128, -128, -128, -128, -128, -128, -128, -128};
      send_row(xs, 0);
      wait_idle();

      set_rom_const(0);
      rom[0] = 8192;
      xs = '{3, 0, 0, 0, 0, 0, 0, 0};
      send_row(xs, 0);
      wait_idle();
      xs = '{-3, 0, 0, 0, 0, 0, 0, 0};
      send_row(xs, 0);
      wait_idle();

      set_rom_identity();
      xs = '{-5, 10, -20, 40, -80, 100, -128, 127};
      send_row(xs, 0);
      wait_index(3, 1'b0);
      out_ready = 1'b0;
      begin
         int t;
         t = 0;
         while (!out_valid && t < 100) begin
            tick();
            t++;
         end
         if (!out_valid) fail("stall_out_valid");
      end
      d0 = out_data;
      i0 = out_index;
      for (int s = 0; s < 5; s++) begin
         tick();
         check("stall_out_valid", out_valid, 1);
         check("stall_out_data", out_data, d0);
         check("stall_out_index", out_index, i0);
         check("stall_rom_read_en", rom_read_en, 0);
         check("stall_busy", busy, 1);
      end
      out_ready = 1'b1;
      wait_idle();

      set_rom_const(16384);
      xs = '{9, 9, 9, 9, 9, 9, 9, 9};
      drive_samples(xs, 5, 0);
      pulse_reset("rst_load");
      xs = '{10, 20, 30, -40, 50, -60, 70, 80};
      send_row(xs, 0);
      wait_idle();

      xs = '{100, 100, 100, 100, 100, 100, 100, 100};
      send_row(xs, 0);
      wait_index(2, 1'b1);
      pulse_reset("rst_fetch");
      xs = '{1, -2, 3, -4, 5, -6, 7, -8};
      send_row(xs, 0);
      wait_idle();

      rand_bp = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 64; i++) rom[i] = int'($urandom_range(0, 131071)) - 65536;
         for (int n = 0; n < 8; n++) xs[n] = int'($urandom_range(0, 255)) - 128;
         send_row(xs, 2);
         if (r == 0) begin
            in_valid  = 1'b1;
            in_sample = 8'sd99;
            repeat (20) tick();
            in_valid = 1'b0;
         end
         wait_idle();
      end
      rand_bp   = 1'b0;
      out_ready = 1'b1;
      tick();

      check("scoreboard_empty", exp_q.size(), 0);
      check("rom_read_outside_fetch", rd_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
